reg_file_mp_scan: RTL and testbench
===================================

// Module: reg_file_mp_scan
// PURPOSE
//  Multi-read-port register file (1 write, NUM_RD combinational reads) with per-port write->read
//  bypass, per-entry zero flags and a nonzero-entry population count. Adds a sequential sparse
//  scanner that walks the array and streams (addr, data) of nonzero entries over valid/ready.
//  Sits in the PE datapath feeding sparse activation/weight fetch for the neural network.
// PARAMETERS
//  BIT_WIDTH  16  entry width in bits
//  REG_DEPTH  64  number of entries (>=2); AW = clog2(REG_DEPTH) (local, via the clog2 function)
//  NUM_RD     2   number of independent read ports (>=1)
// PORTS
//  clk         in   1             system clock, all state on posedge
//  rst_n       in   1             asynchronous active-low reset
//  clear       in   1             synchronous clear of all entries + scan abort
//  read_en     in   NUM_RD        per-port read enable
//  read_addr   in   NUM_RD*AW     port p address at [p*AW +: AW]
//  read_data   out  NUM_RD*BW     port p data at [p*BIT_WIDTH +: BIT_WIDTH], combinational
//  write_en    in   1             write enable
//  write_addr  in   AW            write address
//  write_data  in   BIT_WIDTH     write data
//  zeros       out  REG_DEPTH     zeros[i]=1 iff entry i == 0
//  nz_count    out  AW+1          number of nonzero entries (combinational popcount of ~zeros)
//  scan_start  in   1             start a scan (sampled only in IDLE)
//  scan_busy   out  1             1 in SEEK or HOLD
//  scan_valid  out  1             scan_addr/scan_data valid (HOLD state)
//  scan_ready  in   1             consumer accepts current item
//  scan_addr   out  AW            address of reported nonzero entry
//  scan_data   out  BIT_WIDTH     entry value captured when found
//  scan_done   out  1             one-cycle pulse after scan completes normally
// BEHAVIOUR
//  - Reset (rst_n=0, async): all entries 0, zeros all 1, nz_count 0, FSM IDLE, scan_* outputs 0.
//  - Write: on posedge, clear=1 -> all entries 0 (write dropped); else write_en -> array[write_addr].
//  - Read port p: read_en[p]=0 -> 0; write_en && !clear && write_addr==read_addr[p] -> write_data
//    (bypass); else array[read_addr[p]]. Ports fully independent; same address on all ports legal.
//  - zeros/nz_count reflect registered array contents only (no bypass).
//  - Scan FSM, one entry examined per cycle, pointer ptr (AW bits):
//    IDLE: scan_start=1 -> ptr=0, SEEK.
//    SEEK: array[ptr]!=0 -> latch scan_addr=ptr, scan_data=array[ptr], HOLD;
//          else ptr==REG_DEPTH-1 -> scan_done pulse, IDLE; else ptr++.
//    HOLD: scan_valid=1, addr/data stable until scan_ready=1; on accept:
//          ptr==REG_DEPTH-1 -> scan_done pulse, IDLE; else ptr++, SEEK.
//  - Entry examined is the registered value at that cycle; writes to entries > ptr are seen,
//    writes to entries <= ptr are not; writes to the held entry do not alter scan_data.
//  - scan_start while busy: ignored. scan_start with clear same cycle: clear wins, stays IDLE.
//  - clear in SEEK/HOLD: FSM -> IDLE next cycle, scan_valid drops, no scan_done.
//  - Reset mid-scan: immediate IDLE, no scan_done.
//  - Latency: start at edge t0 with all-zero array -> scan_done high in cycle t0+REG_DEPTH.
//    Nonzero entry k found with no stalls -> scan_valid high k+1 cycles after start edge.
//  - ptr never wraps; last-entry detection uses ptr==REG_DEPTH-1 (works for non-pow2 depth).
// TESTING (REG_DEPTH=8, BIT_WIDTH=16, NUM_RD=2 unless noted)
//  1 Reset then read all addrs both ports -> 0; zeros=8'hFF; nz_count=0; scan_busy=0.
//  2 write addr3=16'h00A5 and read port0 addr3, port1 addr3 same cycle -> both 16'h00A5 (bypass);
//    next cycle zeros=8'hF7, nz_count=1; read_en=0 -> 16'h0000.
//  3 entries 1=5, 4=9, 7=2, scan_ready=1 -> items (1,5),(4,9),(7,2) in order, then scan_done
//    one cycle; scan_busy low after.
//  4 same contents, scan_ready held 0 for 5 cycles on item (4,9) while writing addr4=16'h0077
//    -> scan_data stays 9; write addr6=3 during stall -> (6,3) reported before (7,2).
//  5 all-zero array, scan_start -> no scan_valid, scan_done exactly 8 cycles after start edge.
//  6 clear during HOLD -> scan_valid 0 next cycle, no scan_done, zeros=8'hFF; rst_n low
//    mid-SEEK -> IDLE immediately; REG_DEPTH=5 build: scan covers addrs 0..4 only.

Source files
------------

// File: rtl/reg_file_mp_scan_if.sv
// Signal bundle for reg_file_mp_scan: read ports, write port, entry status and
// the valid/ready stream of nonzero entries produced by the sparse scanner.
interface reg_file_mp_scan_if #(
    parameter int BIT_WIDTH = 16,
    parameter int REG_DEPTH = 64,
    parameter int NUM_RD    = 2
);
    localparam int AW = $clog2(REG_DEPTH);

    logic                        clear;
    logic [NUM_RD-1:0]           read_en;
    logic [NUM_RD*AW-1:0]        read_addr;
    logic [NUM_RD*BIT_WIDTH-1:0] read_data;
    logic                        write_en;
    logic [AW-1:0]               write_addr;
    logic [BIT_WIDTH-1:0]        write_data;
    logic [REG_DEPTH-1:0]        zeros;
    logic [AW:0]                 nz_count;
    logic                        scan_start;
    logic                        scan_busy;
    logic                        scan_valid;
    logic                        scan_ready;
    logic [AW-1:0]               scan_addr;
    logic [BIT_WIDTH-1:0]        scan_data;
    logic                        scan_done;

    modport master (
        output clear, read_en, read_addr, write_en, write_addr, write_data,
               scan_start, scan_ready,
        input  read_data, zeros, nz_count, scan_busy, scan_valid, scan_addr,
               scan_data, scan_done
    );

    modport slave (
        input  clear, read_en, read_addr, write_en, write_addr, write_data,
               scan_start, scan_ready,
        output read_data, zeros, nz_count, scan_busy, scan_valid, scan_addr,
               scan_data, scan_done
    );
endinterface

// File: rtl/reg_file_mp_scan.sv
// Multi-read-port register file with write->read bypass, zero flags, nonzero popcount
// and a sequential scanner that streams (addr, data) of nonzero entries over valid/ready.
module reg_file_mp_scan #(
    parameter int BIT_WIDTH = 16,
    parameter int REG_DEPTH = 64,
    parameter int NUM_RD    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_file_mp_scan_if.slave bus
);
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    localparam int            AW   = clog2(REG_DEPTH);
    localparam logic [AW-1:0] LAST = AW'(REG_DEPTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEEK = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [BIT_WIDTH-1:0] mem_q [REG_DEPTH];

    logic                 wr_in_range;
    logic                 wr_fire;

    // Non-power-of-two depths leave part of the address space unmapped.
    assign wr_in_range = {1'b0, bus.write_addr} < (AW+1)'(REG_DEPTH);
    assign wr_fire     = bus.write_en && !bus.clear && wr_in_range;

    // NOTE: the array is reset asynchronously because the zero flags and the scanner
    // must see all-zero contents straight out of reset, not after a sweep of writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_DEPTH; i++) mem_q[i] <= '0;
        end else if (bus.clear) begin
            for (int i = 0; i < REG_DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_fire) begin
            // NOTE: non-blocking assignment so every reader in this edge sees the old value.
            mem_q[bus.write_addr] <= bus.write_data;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]        rd_addr;
        logic                 rd_in_range;
        logic [BIT_WIDTH-1:0] rd_data;

        assign rd_addr     = bus.read_addr[p*AW +: AW];
        assign rd_in_range = {1'b0, rd_addr} < (AW+1)'(REG_DEPTH);

        always_comb begin
            // NOTE: default first so no path through the if-chain can infer a latch.
            rd_data = '0;
            if (!bus.read_en[p]) begin
                rd_data = '0;
            end else if (wr_fire && bus.write_addr == rd_addr) begin
                rd_data = bus.write_data;
            end else if (rd_in_range) begin
                rd_data = mem_q[rd_addr];
            end
        end

        assign bus.read_data[p*BIT_WIDTH +: BIT_WIDTH] = rd_data;
    end

    logic [REG_DEPTH-1:0] zeros_w;
    logic [AW:0]          nz_w;

    // Status reflects only the registered contents; an in-flight write is not counted.
    always_comb begin
        zeros_w = '0;
        nz_w    = '0;
        for (int i = 0; i < REG_DEPTH; i++) begin
            zeros_w[i] = (mem_q[i] == '0);
            nz_w       = nz_w + (AW+1)'(!zeros_w[i]);
        end
    end

    assign bus.zeros    = zeros_w;
    assign bus.nz_count = nz_w;

    logic [1:0]           state_q, state_d;
    logic [AW-1:0]        ptr_q, ptr_d;
    logic [AW-1:0]        scan_addr_q, scan_addr_d;
    logic [BIT_WIDTH-1:0] scan_data_q, scan_data_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        scan_addr_d = scan_addr_q;
        scan_data_d = scan_data_q;
        done_d      = 1'b0;
        if (bus.clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.scan_start) begin
                        ptr_d   = '0;
                        state_d = SEEK;
                    end
                end
                SEEK: begin
                    // Data is captured here so later writes to the held entry don't leak out.
                    if (mem_q[ptr_q] != '0) begin
                        scan_addr_d = ptr_q;
                        scan_data_d = mem_q[ptr_q];
                        state_d     = HOLD;
                    end else if (ptr_q == LAST) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ptr_d = ptr_q + AW'(1);
                    end
                end
                HOLD: begin
                    if (bus.scan_ready) begin
                        if (ptr_q == LAST) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ptr_d   = ptr_q + AW'(1);
                            state_d = SEEK;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            scan_addr_q <= '0;
            scan_data_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            scan_addr_q <= scan_addr_d;
            scan_data_q <= scan_data_d;
            done_q      <= done_d;
        end
    end

    assign bus.scan_busy  = (state_q != IDLE);
    assign bus.scan_valid = (state_q == HOLD);
    assign bus.scan_addr  = scan_addr_q;
    assign bus.scan_data  = scan_data_q;
    assign bus.scan_done  = done_q;

endmodule

// File: tb/tb_reg_file_mp_scan.sv
// Directed bench for reg_file_mp_scan: depth-8 instance for the main function and a
// depth-5 instance for the non-power-of-two scan range.
module tb_reg_file_mp_scan;
    logic clk;
    logic rst_n;

    int tests_run;
    int tests_failed;

    int got_addr [8];
    int got_data [8];
    int got_cyc  [8];
    int n_items;
    int done_cyc;

    reg_file_mp_scan_if #(.BIT_WIDTH(16), .REG_DEPTH(8), .NUM_RD(2)) bus  ();
    reg_file_mp_scan_if #(.BIT_WIDTH(16), .REG_DEPTH(5), .NUM_RD(2)) bus5 ();

    reg_file_mp_scan #(.BIT_WIDTH(16), .REG_DEPTH(8), .NUM_RD(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    reg_file_mp_scan #(.BIT_WIDTH(16), .REG_DEPTH(5), .NUM_RD(2)) u_dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        bus.write_en   = 1'b1;
        bus.write_addr = 3'(a);
        bus.write_data = 16'(d);
        tick();
        bus.write_en   = 1'b0;
    endtask

    task automatic start_scan();
        bus.scan_start = 1'b1;
        tick();
        bus.scan_start = 1'b0;
    endtask

    // Cycle c=1 is the observation just after the first edge following the start edge.
    task automatic collect(input int max_cycles, input int stop_addr);
        done_cyc = -1;
        for (int c = 1; c <= max_cycles; c++) begin
            tick();
            if (bus.scan_valid) begin
                if (n_items < 8) begin
                    got_addr[n_items] = int'(bus.scan_addr);
                    got_data[n_items] = int'(bus.scan_data);
                    got_cyc[n_items]  = c;
                end
                n_items++;
                if (int'(bus.scan_addr) == stop_addr) return;
            end
            if (bus.scan_done) begin
                done_cyc = c;
                return;
            end
        end
        check("collect_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int n5;
        int done5;
        int done_seen;
        int a5 [4];
        int d5 [4];
        int c5 [4];

        tests_run    = 0;
        tests_failed = 0;
        n_items      = 0;
        done_cyc     = -1;

        bus.clear = 1'b0;  bus.read_en = '0;  bus.read_addr = '0;
        bus.write_en = 1'b0;  bus.write_addr = '0;  bus.write_data = '0;
        bus.scan_start = 1'b0;  bus.scan_ready = 1'b1;
        bus5.clear = 1'b0;  bus5.read_en = '0;  bus5.read_addr = '0;
        bus5.write_en = 1'b0;  bus5.write_addr = '0;  bus5.write_data = '0;
        bus5.scan_start = 1'b0;  bus5.scan_ready = 1'b1;

        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;

        // 1: reset state
        bus.read_en = 2'b11;
        for (int a = 0; a < 8; a++) begin
            bus.read_addr = {3'(a), 3'(a)};
            #1;
            check($sformatf("rst_rd_p0_a%0d", a), bus.read_data[15:0],  16'h0000);
            check($sformatf("rst_rd_p1_a%0d", a), bus.read_data[31:16], 16'h0000);
        end
        check("rst_zeros",    bus.zeros,     8'hFF);
        check("rst_nz_count", bus.nz_count,  4'd0);
        check("rst_busy",     bus.scan_busy, 1'b0);
        check("rst_valid",    bus.scan_valid, 1'b0);

        // 2: same-cycle bypass on both ports, then registered status
        tick();
        bus.read_addr  = {3'd3, 3'd3};
        bus.write_en   = 1'b1;
        bus.write_addr = 3'd3;
        bus.write_data = 16'h00A5;
        #1;
        check("bypass_p0", bus.read_data[15:0],  16'h00A5);
        check("bypass_p1", bus.read_data[31:16], 16'h00A5);
        check("bypass_zeros_unchanged", bus.zeros, 8'hFF);
        tick();
        bus.write_en = 1'b0;
        #1;
        check("wr_zeros",    bus.zeros,    8'hF7);
        check("wr_nz_count", bus.nz_count, 4'd1);
        check("wr_rd_p0",    bus.read_data[15:0], 16'h00A5);
        bus.read_addr = {3'd2, 3'd3};
        #1;
        check("rd_p1_other_addr", bus.read_data[31:16], 16'h0000);
        bus.read_en = 2'b00;
        #1;
        check("rd_dis_p0", bus.read_data[15:0],  16'h0000);
        check("rd_dis_p1", bus.read_data[31:16], 16'h0000);

        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("clear_zeros", bus.zeros, 8'hFF);

        // 3: free-running scan
        wr(1, 5);
        wr(4, 9);
        wr(7, 2);
        check("t3_nz_count", bus.nz_count, 4'd3);
        bus.scan_ready = 1'b1;
        n_items = 0;
        start_scan();
        check("t3_busy_after_start", bus.scan_busy, 1'b1);
        collect(40, -1);
        check("t3_n_items", n_items, 3);
        check("t3_item0_addr", got_addr[0], 1);
        check("t3_item0_data", got_data[0], 5);
        check("t3_item0_cyc",  got_cyc[0],  2);
        check("t3_item1_addr", got_addr[1], 4);
        check("t3_item1_data", got_data[1], 9);
        check("t3_item2_addr", got_addr[2], 7);
        check("t3_item2_data", got_data[2], 2);
        check("t3_done_cyc",   done_cyc,    11);
        check("t3_busy_at_done", bus.scan_busy, 1'b0);
        tick();
        check("t3_done_one_cycle", bus.scan_done, 1'b0);
        check("t3_busy_after", bus.scan_busy, 1'b0);

        // 4: stall on (4,9) while writing the held entry and a later entry
        n_items = 0;
        start_scan();
        collect(40, 4);
        check("t4_first_items", n_items, 2);
        bus.scan_ready = 1'b0;
        bus.write_en   = 1'b1;
        bus.write_addr = 3'd4;
        bus.write_data = 16'h0077;
        tick();
        bus.write_addr = 3'd6;
        bus.write_data = 16'h0003;
        for (int s = 0; s < 4; s++) begin
            check($sformatf("t4_stall%0d_valid", s), bus.scan_valid, 1'b1);
            check($sformatf("t4_stall%0d_addr", s),  bus.scan_addr,  3'd4);
            check($sformatf("t4_stall%0d_data", s),  bus.scan_data,  16'h0009);
            tick();
            bus.write_en = 1'b0;
        end
        check("t4_stall4_data", bus.scan_data, 16'h0009);
        bus.read_en   = 2'b01;
        bus.read_addr = {3'd0, 3'd4};
        #1;
        check("t4_entry4_written", bus.read_data[15:0], 16'h0077);
        bus.read_en    = 2'b00;
        bus.scan_ready = 1'b1;
        collect(40, -1);
        check("t4_n_items",    n_items, 4);
        check("t4_item2_addr", got_addr[2], 6);
        check("t4_item2_data", got_data[2], 3);
        check("t4_item3_addr", got_addr[3], 7);
        check("t4_item3_data", got_data[3], 2);
        check("t4_done_seen",  done_cyc > 0, 1'b1);

        // 5: all-zero array
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        n_items = 0;
        start_scan();
        collect(40, -1);
        check("t5_n_items",  n_items,  0);
        check("t5_done_cyc", done_cyc, 8);

        // 6a: clear during HOLD
        wr(2, 16'h0011);
        n_items = 0;
        start_scan();
        collect(40, 2);
        check("t6_found_cyc", got_cyc[0], 3);
        check("t6_hold_valid", bus.scan_valid, 1'b1);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("t6_clr_valid", bus.scan_valid, 1'b0);
        check("t6_clr_busy",  bus.scan_busy,  1'b0);
        check("t6_clr_zeros", bus.zeros,      8'hFF);
        done_seen = int'(bus.scan_done);
        for (int c = 0; c < 10; c++) begin
            tick();
            done_seen += int'(bus.scan_done);
        end
        check("t6_clr_no_done", done_seen, 0);

        // clear and start in the same cycle: clear wins
        bus.clear      = 1'b1;
        bus.scan_start = 1'b1;
        tick();
        bus.clear      = 1'b0;
        bus.scan_start = 1'b0;
        check("t6_clr_start_idle", bus.scan_busy, 1'b0);

        // 6b: reset mid-SEEK
        start_scan();
        tick();
        tick();
        check("t6_seek_busy", bus.scan_busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy",  bus.scan_busy, 1'b0);
        check("t6_rst_done",  bus.scan_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            done_seen += int'(bus.scan_done);
        end
        check("t6_rst_no_done", done_seen, 0);

        // 6c: depth-5 build scans addresses 0..4 only
        bus5.write_en   = 1'b1;
        bus5.write_addr = 3'd0;
        bus5.write_data = 16'h0001;
        tick();
        bus5.write_addr = 3'd4;
        bus5.write_data = 16'h0007;
        tick();
        bus5.write_en = 1'b0;
        check("d5_nz_count", bus5.nz_count, 4'd2);
        check("d5_zeros",    bus5.zeros,    5'b01110);
        bus5.scan_start = 1'b1;
        tick();
        bus5.scan_start = 1'b0;
        n5    = 0;
        done5 = -1;
        for (int c = 1; c <= 30 && done5 < 0; c++) begin
            tick();
            if (bus5.scan_valid) begin
                if (n5 < 4) begin
                    a5[n5] = int'(bus5.scan_addr);
                    d5[n5] = int'(bus5.scan_data);
                    c5[n5] = c;
                end
                n5++;
            end
            if (bus5.scan_done) done5 = c;
        end
        check("d5_n_items",    n5, 2);
        check("d5_item0_addr", a5[0], 0);
        check("d5_item0_data", d5[0], 1);
        check("d5_item0_cyc",  c5[0], 1);
        check("d5_item1_addr", a5[1], 4);
        check("d5_item1_data", d5[1], 7);
        check("d5_done_cyc",   done5, 7);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
